// File: rtl/rx_decoder_8b10b.sv
// rtl/rx_decoder_8b10b.sv - serial 8b/10b receiver with K28.5 word alignment and disparity tracking
module rx_decoder_8b10b #(
    parameter int LOCK_COMMAS = 3,
    parameter int UNLOCK_ERRS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bitValid,
    input  logic       serialIn,
    output logic [7:0] dataOut,
    output logic       dataValid,
    output logic       commaOut,
    output logic       codeErr,
    output logic       dispErr,
    output logic       locked,
    output logic       RDout
);
    localparam logic [9:0] K28_5_NEG = 10'b0011111010;
    localparam logic [9:0] K28_5_POS = 10'b1100000101;
    localparam int CCW = $clog2(LOCK_COMMAS + 1);
    localparam int ECW = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {HUNT, SYNC, LOCKED} state_t;

    state_t         state;
    logic [8:0]     shift_reg;
    logic [3:0]     bit_cnt;
    logic [CCW-1:0] comma_cnt;
    logic [ECW-1:0] err_cnt;

    // Lookups return {in RD- column, in RD+ column, value}; unknown codes give all zeros.
    function automatic logic [6:0] dec6(input logic [5:0] c);
        case (c)
            6'b100111: dec6 = {2'b10, 5'd0};  6'b011000: dec6 = {2'b01, 5'd0};
            6'b011101: dec6 = {2'b10, 5'd1};  6'b100010: dec6 = {2'b01, 5'd1};
            6'b101101: dec6 = {2'b10, 5'd2};  6'b010010: dec6 = {2'b01, 5'd2};
            6'b110001: dec6 = {2'b11, 5'd3};
            6'b110101: dec6 = {2'b10, 5'd4};  6'b001010: dec6 = {2'b01, 5'd4};
            6'b101001: dec6 = {2'b11, 5'd5};  6'b011001: dec6 = {2'b11, 5'd6};
            6'b111000: dec6 = {2'b10, 5'd7};  6'b000111: dec6 = {2'b01, 5'd7};
            6'b111001: dec6 = {2'b10, 5'd8};  6'b000110: dec6 = {2'b01, 5'd8};
            6'b100101: dec6 = {2'b11, 5'd9};  6'b010101: dec6 = {2'b11, 5'd10};
            6'b110100: dec6 = {2'b11, 5'd11}; 6'b001101: dec6 = {2'b11, 5'd12};
            6'b101100: dec6 = {2'b11, 5'd13}; 6'b011100: dec6 = {2'b11, 5'd14};
            6'b010111: dec6 = {2'b10, 5'd15}; 6'b101000: dec6 = {2'b01, 5'd15};
            6'b011011: dec6 = {2'b10, 5'd16}; 6'b100100: dec6 = {2'b01, 5'd16};
            6'b100011: dec6 = {2'b11, 5'd17}; 6'b010011: dec6 = {2'b11, 5'd18};
            6'b110010: dec6 = {2'b11, 5'd19}; 6'b001011: dec6 = {2'b11, 5'd20};
            6'b101010: dec6 = {2'b11, 5'd21}; 6'b011010: dec6 = {2'b11, 5'd22};
            6'b111010: dec6 = {2'b10, 5'd23}; 6'b000101: dec6 = {2'b01, 5'd23};
            6'b110011: dec6 = {2'b10, 5'd24}; 6'b001100: dec6 = {2'b01, 5'd24};
            6'b100110: dec6 = {2'b11, 5'd25}; 6'b010110: dec6 = {2'b11, 5'd26};
            6'b110110: dec6 = {2'b10, 5'd27}; 6'b001001: dec6 = {2'b01, 5'd27};
            6'b001110: dec6 = {2'b11, 5'd28};
            6'b101110: dec6 = {2'b10, 5'd29}; 6'b010001: dec6 = {2'b01, 5'd29};
            6'b011110: dec6 = {2'b10, 5'd30}; 6'b100001: dec6 = {2'b01, 5'd30};
            6'b101011: dec6 = {2'b10, 5'd31}; 6'b010100: dec6 = {2'b01, 5'd31};
            default:   dec6 = 7'd0;
        endcase
    endfunction

    function automatic logic [4:0] dec4(input logic [3:0] c);
        case (c)
            4'b1011: dec4 = {2'b10, 3'd0};  4'b0100: dec4 = {2'b01, 3'd0};
            4'b1001: dec4 = {2'b11, 3'd1};  4'b0101: dec4 = {2'b11, 3'd2};
            4'b1100: dec4 = {2'b10, 3'd3};  4'b0011: dec4 = {2'b01, 3'd3};
            4'b1101: dec4 = {2'b10, 3'd4};  4'b0010: dec4 = {2'b01, 3'd4};
            4'b1010: dec4 = {2'b11, 3'd5};  4'b0110: dec4 = {2'b11, 3'd6};
            4'b1110: dec4 = {2'b10, 3'd7};  4'b0001: dec4 = {2'b01, 3'd7};
            default: dec4 = 5'd0;
        endcase
    endfunction

    // Only a disparity of exactly +/-2 moves RD; balanced and illegal-weight blocks leave it.
    function automatic logic rd_after(input logic rd, input int ones, input int half);
        if (ones == half + 1)      rd_after = 1'b1;
        else if (ones == half - 1) rd_after = 1'b0;
        else                       rd_after = rd;
    endfunction

    logic [9:0] win;
    logic [6:0] l6;
    logic [4:0] l4;
    logic [7:0] word_data;
    logic       rd_mid, rd_next, hit4, opp4, hit6, opp6;
    logic       is_comma, code_err, disp_err, word_err, word_done;

    always_comb begin
        win       = {shift_reg, serialIn};
        l4        = dec4(win[3:0]);
        l6        = dec6(win[9:4]);
        rd_mid    = rd_after(RDout, $countones(win[3:0]), 2);
        rd_next   = rd_after(rd_mid, $countones(win[9:4]), 3);
        hit4      = RDout  ? l4[3] : l4[4];
        opp4      = RDout  ? l4[4] : l4[3];
        hit6      = rd_mid ? l6[5] : l6[6];
        opp6      = rd_mid ? l6[6] : l6[5];
        is_comma  = (win == K28_5_NEG) || (win == K28_5_POS);
        word_data = {l4[2:0], l6[4:0]};
        code_err  = !(hit4 || opp4) || !(hit6 || opp6);
        disp_err  = (!hit4 && opp4) || (!hit6 && opp6);
        if (is_comma) begin
            word_data = 8'hBC;
            code_err  = 1'b0;
            disp_err  = RDout ^ win[9];
        end
        word_err  = code_err || disp_err;
        word_done = bitValid && (bit_cnt == 4'd9);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= HUNT;
            shift_reg <= '0;
            bit_cnt   <= '0;
            comma_cnt <= '0;
            err_cnt   <= '0;
            dataOut   <= '0;
            dataValid <= 1'b0;
            commaOut  <= 1'b0;
            codeErr   <= 1'b0;
            dispErr   <= 1'b0;
            locked    <= 1'b0;
            RDout     <= 1'b0;
        end else begin
            dataValid <= 1'b0;
            if (bitValid) begin
                shift_reg <= win[8:0];
                bit_cnt   <= (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
                case (state)
                    HUNT: if (is_comma) begin
                        bit_cnt   <= 4'd0;
                        RDout     <= ~win[9];
                        comma_cnt <= CCW'(1);
                        err_cnt   <= '0;
                        if (LOCK_COMMAS == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= SYNC;
                        end
                    end
                    SYNC: if (word_done) begin
                        RDout <= rd_next;
                        if (word_err) begin
                            state <= HUNT;
                        end else if (is_comma) begin
                            comma_cnt <= comma_cnt + CCW'(1);
                            if (comma_cnt + CCW'(1) == CCW'(LOCK_COMMAS)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: if (word_done) begin
                        RDout     <= rd_next;
                        dataValid <= 1'b1;
                        dataOut   <= word_data;
                        commaOut  <= is_comma;
                        codeErr   <= code_err;
                        dispErr   <= disp_err;
                        if (!word_err) begin
                            err_cnt <= '0;
                        end else if (err_cnt + ECW'(1) == ECW'(UNLOCK_ERRS)) begin
                            state  <= HUNT;
                            locked <= 1'b0;
                        end else begin
                            err_cnt <= err_cnt + ECW'(1);
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rx_decoder_8b10b.sv
// tb/tb_rx_decoder_8b10b.sv - randomized bench for rx_decoder_8b10b against a table-driven link model
module tb_rx_decoder_8b10b;
    localparam int LOCK   = 3;
    localparam int UNLOCK = 4;
    localparam bit [9:0] K_NEG = 10'b0011111010;
    localparam bit [9:0] K_POS = 10'b1100000101;
    // RD- codes for D.0..D.31 and D.x.0..D.x.7; RD+ codes are derived from them.
    localparam bit [5:0] N6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
    localparam bit [3:0] N4 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                                    4'b1101, 4'b1010, 4'b0110, 4'b1110};

    logic       clk = 1'b0;
    logic       reset, bitValid, serialIn;
    logic [7:0] dataOut;
    logic       dataValid, commaOut, codeErr, dispErr, locked, RDout;

    int checks  = 0;
    int errors  = 0;
    int dv_seen = 0;

    bit [8:0] m_hist;
    bit       m_aligned, m_lock, m_rd;
    int       m_pos, m_commas, m_errs;
    bit [7:0] e_data;
    bit       e_dv, e_k, e_ce, e_de;

    rx_decoder_8b10b #(.LOCK_COMMAS(LOCK), .UNLOCK_ERRS(UNLOCK)) dut (
        .clk(clk), .reset(reset), .bitValid(bitValid), .serialIn(serialIn),
        .dataOut(dataOut), .dataValid(dataValid), .commaOut(commaOut), .codeErr(codeErr),
        .dispErr(dispErr), .locked(locked), .RDout(RDout));

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit [5:0] p6(input int x);
        return ($countones(N6[x]) != 3 || x == 7) ? ~N6[x] : N6[x];
    endfunction

    function automatic bit [3:0] p4(input int y);
        return ($countones(N4[y]) != 2 || y == 3) ? ~N4[y] : N4[y];
    endfunction

    function automatic bit rd_after(input bit rd, input int ones, input int width);
        int disp;
        disp = 2 * ones - width;
        if (disp == 2)  return 1'b1;
        if (disp == -2) return 1'b0;
        return rd;
    endfunction

    task automatic look6(input bit [5:0] c, input bit rd, output bit cur, output bit opp, output bit [4:0] v);
        cur = 0; opp = 0; v = 0;
        for (int x = 0; x < 32; x++) begin
            if (c == (rd ? p6(x) : N6[x])) begin cur = 1; v = 5'(x); end
            if (c == (rd ? N6[x] : p6(x))) begin opp = 1; v = 5'(x); end
        end
    endtask

    task automatic look4(input bit [3:0] c, input bit rd, output bit cur, output bit opp, output bit [2:0] v);
        cur = 0; opp = 0; v = 0;
        for (int y = 0; y < 8; y++) begin
            if (c == (rd ? p4(y) : N4[y])) begin cur = 1; v = 3'(y); end
            if (c == (rd ? N4[y] : p4(y))) begin opp = 1; v = 3'(y); end
        end
    endtask

    task automatic decode(input bit [9:0] w, input bit rd, output bit [7:0] d,
                          output bit k, output bit ce, output bit de, output bit rd_o);
        bit c4, o4, c6, o6, rdm;
        bit [2:0] v4;
        bit [4:0] v6;
        rdm  = rd_after(rd, $countones(w[3:0]), 4);
        rd_o = rd_after(rdm, $countones(w[9:4]), 6);
        look4(w[3:0], rd, c4, o4, v4);
        look6(w[9:4], rdm, c6, o6, v6);
        d  = {v4, v6};
        k  = 0;
        ce = (!c4 && !o4) || (!c6 && !o6);
        de = (!c4 && o4) || (!c6 && o6);
        if (w == K_NEG || w == K_POS) begin
            d = 8'hBC; k = 1; ce = 0;
            de = (w == K_NEG) ? rd : !rd;
        end
    endtask

    function automatic bit [9:0] encode(input bit [7:0] b, input bit rd);
        bit [3:0] c4;
        bit [5:0] c6;
        bit rdm;
        c4  = rd ? p4(int'(b[7:5])) : N4[b[7:5]];
        rdm = rd_after(rd, $countones(c4), 4);
        c6  = rdm ? p6(int'(b[4:0])) : N6[b[4:0]];
        return {c6, c4};
    endfunction

    task automatic model_reset();
        m_hist = 0; m_aligned = 0; m_lock = 0; m_rd = 0;
        m_pos = 0; m_commas = 0; m_errs = 0;
        e_data = 0; e_dv = 0; e_k = 0; e_ce = 0; e_de = 0;
    endtask

    task automatic model_step(input bit b);
        bit [9:0] w;
        bit [7:0] d;
        bit k, ce, de, rdo;
        w = {m_hist, b};
        m_hist = w[8:0];
        if (!m_aligned) begin
            if (w == K_NEG || w == K_POS) begin
                m_aligned = 1; m_pos = 0; m_rd = (w == K_NEG);
                m_commas = 1; m_errs = 0;
                if (m_commas >= LOCK) m_lock = 1;
            end
            return;
        end
        m_pos++;
        if (m_pos < 10) return;
        m_pos = 0;
        decode(w, m_rd, d, k, ce, de, rdo);
        m_rd = rdo;
        if (!m_lock) begin
            if (ce || de) m_aligned = 0;
            else if (k) begin
                m_commas++;
                if (m_commas == LOCK) m_lock = 1;
            end
        end else begin
            e_dv = 1; e_data = d; e_k = k; e_ce = ce; e_de = de;
            if (ce || de) begin
                m_errs++;
                if (m_errs == UNLOCK) begin m_lock = 0; m_aligned = 0; end
            end else begin
                m_errs = 0;
            end
        end
    endtask

    task automatic clock_bit(input bit v, input bit b);
        bitValid = v;
        serialIn = b;
        @(posedge clk);
        e_dv = 0;
        if (v) model_step(b);
        #1;
        if (dataValid === 1'b1) dv_seen++;
        chk1("dataValid", dataValid, e_dv);
        chk1("locked", locked, m_lock);
        chk1("RDout", RDout, m_rd);
        chk8("dataOut", dataOut, e_data);
        chk1("commaOut", commaOut, e_k);
        chk1("codeErr", codeErr, e_ce);
        chk1("dispErr", dispErr, e_de);
    endtask

    task automatic send_bit(input bit b);
        if ($urandom_range(0, 5) == 0) clock_bit(1'b0, 1'($urandom));
        clock_bit(1'b1, b);
    endtask

    task automatic send_word(input bit [9:0] w);
        for (int i = 9; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic safe_bit(input bit b);
        bit [9:0] w;
        w = {m_hist, b};
        if (w == K_NEG || w == K_POS) b = ~b;
        send_bit(b);
    endtask

    task automatic check_all_zero(input string tag);
        chk8({tag, "_dataOut"}, dataOut, 8'h00);
        chk1({tag, "_dataValid"}, dataValid, 1'b0);
        chk1({tag, "_commaOut"}, commaOut, 1'b0);
        chk1({tag, "_codeErr"}, codeErr, 1'b0);
        chk1({tag, "_dispErr"}, dispErr, 1'b0);
        chk1({tag, "_locked"}, locked, 1'b0);
        chk1({tag, "_RDout"}, RDout, 1'b0);
    endtask

    task automatic send_commas();
        for (int i = 0; i < 30; i++) send_bit(1'b0);
        send_word(K_NEG);
        send_word(K_POS);
        send_word(K_NEG);
    endtask

    initial begin
        bit [9:0] w;
        bit [7:0] b;
        reset = 0; bitValid = 0; serialIn = 0;
        model_reset();
        #1 reset = 1;
        #1 check_all_zero("reset");
        @(negedge clk) reset = 0;

        for (int i = 0; i < 200; i++) safe_bit(1'($urandom));
        for (int i = 0; i < 30; i++) safe_bit(1'b0);
        chk1("hunt_locked", locked, 1'b0);
        chkn("hunt_no_dv", dv_seen, 0);

        send_word(K_NEG);
        send_word(K_POS);
        w = K_NEG;
        for (int i = 9; i >= 1; i--) send_bit(w[i]);
        chk1("lock_bit29", locked, 1'b0);
        send_bit(w[0]);
        chk1("lock_bit30", locked, 1'b1);
        chk1("lock_rd", RDout, 1'b1);
        chkn("lock_no_dv", dv_seen, 0);

        send_word(K_POS);
        chk1("comma_dv", dataValid, 1'b1);
        chk1("comma_flag", commaOut, 1'b1);
        chk8("comma_data", dataOut, 8'hBC);
        send_word(10'b0110001011);
        chk1("d00_dv", dataValid, 1'b1);
        chk8("d00_data", dataOut, 8'h00);
        chk1("d00_codeErr", codeErr, 1'b0);
        chk1("d00_dispErr", dispErr, 1'b0);
        chk1("d00_rd", RDout, 1'b0);
        send_word(10'b1010101010);
        chk8("db5_data", dataOut, 8'hB5);
        chk1("db5_rd", RDout, 1'b0);

        send_word(10'b1001110100);
        chk8("derr_data", dataOut, 8'h00);
        chk1("derr_dispErr", dispErr, 1'b1);
        chk1("derr_codeErr", codeErr, 1'b0);
        chk1("derr_rd", RDout, 1'b1);

        for (int i = 0; i < 60; i++) begin
            b = 8'($urandom);
            send_word(encode(b, m_rd));
            chk8("rand_data", dataOut, b);
            chk1("rand_codeErr", codeErr, 1'b0);
            chk1("rand_dispErr", dispErr, 1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            send_word(10'd0);
            chk1("cerr_flag", codeErr, 1'b1);
            chk1("cerr_locked", locked, 1'b1);
        end
        b = 8'($urandom);
        send_word(encode(b, m_rd));
        chk1("cerr_recover", codeErr, 1'b0);
        chk1("cerr_keep_lock", locked, 1'b1);
        for (int i = 0; i < 4; i++) begin
            send_word(10'd0);
            chk1("unlock_flag", codeErr, 1'b1);
            chk1("unlock_locked", locked, i < 3);
        end
        chk1("unlock_dv", dataValid, 1'b1);

        send_commas();
        chk1("relock", locked, 1'b1);

        send_bit(1'b0);
        send_word(K_POS);
        chk1("misalign_no_comma", commaOut, 1'b0);
        chk1("misalign_still_locked", locked, 1'b1);
        for (int i = 0; i < 5; i++) send_word(10'd0);
        chk1("misalign_unlock", locked, 1'b0);
        send_commas();
        chk1("misalign_relock", locked, 1'b1);
        chk1("misalign_rd", RDout, 1'b1);

        for (int i = 0; i < 3; i++) send_word(encode(8'($urandom), m_rd));
        w = encode(8'($urandom), m_rd);
        for (int i = 9; i >= 5; i--) send_bit(w[i]);
        #2 reset = 1;
        #1 check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        @(negedge clk) reset = 0;
        for (int i = 0; i < 100; i++) safe_bit(1'($urandom));
        chk1("post_reset_locked", locked, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_decoder_8b10b.md
# rx_decoder_8b10b

Serial-in 8b/10b receive block for the SERDES link: deserializes a bit stream and finds word alignment by hunting for the K28.5 comma. It tracks running disparity and decodes each aligned 10-bit codeword to a byte plus comma, code-error and disparity-error flags. It sits after the link's bit sampler and is the receive-side counterpart of the link's 8b/10b encoder, using the same codeword layout and disparity order.

## Interface
- LOCK_COMMAS, default 3: commas needed, counting the aligning comma, before declaring lock (≥1).
- UNLOCK_ERRS, default 4: consecutive errored words in LOCKED that force re-hunt (≥1).

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- bitValid  in  1  serialIn carries a new bit this cycle.
- serialIn  in  1  received bit; codeword bit 9 is transmitted first.
- dataOut  out  8  decoded byte; 8'hBC for the comma.
- dataValid  out  1  one-cycle pulse per decoded word, LOCKED only.
- commaOut  out  1  word was K28.5; qualified by dataValid.
- codeErr  out  1  word not in code table; qualified by dataValid.
- dispErr  out  1  a sub-block came from the wrong disparity column; qualified by dataValid.
- locked  out  1  state is LOCKED.
- RDout  out  1  current running disparity (1 = RD+, 0 = RD−).

## Operation
- Window: win = {shiftReg[8:0], serialIn}. On each bitValid, shiftReg ← win.
- Codeword layout: win[9:4] = 6b sub-block abcdei (a = bit 9), which decodes to data[4:0]. win[3:0] = 4b sub-block fghj (f = bit 3), which decodes to data[7:5].
- Code tables: standard 5b/6b and 3b/4b tables. D.x.7 uses the primary code only (RD− 1110, RD+ 0001); there is no alternate A7.
- The only control code is K28.5: RD− 0011111010, RD+ 1100000101.
- Disparity order: the 4b sub-block is checked against the running RD first, giving RDmid; the 6b sub-block is then checked against RDmid.
- Per sub-block lookup:
  - Code present in the current-RD column: no error.
  - Code present only in the opposite column: dispErr.
  - Code present in neither column: codeErr; dataOut bits for that sub-block = 0.
- Per sub-block RD update:
  - Balanced: RD unchanged.
  - Disparity +2: RD = 1.
  - Disparity −2: RD = 0.
  - Disparity magnitude >2: RD unchanged.
  - The update applies even when dispErr is flagged.
- K28.5 in the wrong RD: commaOut=1, dispErr=1, RD updated as above.
- bitCnt (0–9) advances on bitValid only. A word completes on the bitValid edge where bitCnt==9; bitCnt then wraps to 0.
- State machine:
  - HUNT: on each bitValid, if win equals either comma:
    - bitCnt ← 0.
    - RD ← 1 for the RD− comma, 0 for the RD+ comma.
    - commaCnt ← 1.
    - Go to SYNC, or directly to LOCKED if LOCK_COMMAS==1.
  - SYNC, on each completed word:
    - Any error → HUNT.
    - Error-free comma → commaCnt+1; go to LOCKED when commaCnt reaches LOCK_COMMAS.
    - Error-free data word → stay in SYNC, no count change.
    - No output pulses in SYNC.
  - LOCKED, on each completed word:
    - Register the outputs and pulse dataValid.
    - Error word → errCnt+1.
    - Error-free word → errCnt ← 0.
    - errCnt reaching UNLOCK_ERRS → HUNT; locked drops on the same edge as that word's dataValid.
- Commas at other bit offsets are ignored in SYNC and LOCKED; there is no realignment outside HUNT.

## Timing
- Reset values:
  - Outputs: dataOut=0, dataValid=0, commaOut=0, codeErr=0, dispErr=0, locked=0, RDout=0.
  - Internal: state=HUNT, shiftReg=0, bitCnt=0, commaCnt=0, errCnt=0.
- Latency: decoded outputs are registered on the same edge that samples the word's 10th bit and are visible the following cycle.
- dataValid is high for exactly one clk. dataOut, commaOut, codeErr and dispErr hold until the next dataValid.
- bitValid low: no shift, no count change, no state change.
- locked asserts on the edge completing the LOCK_COMMAS-th comma.
- RDout updates on every completed word, and on alignment in HUNT.
- Reset mid-word: the partial word is discarded; the bench observes reset values while reset is high.

## Test plan
- Reset: drive reset mid-stream → all outputs 0 asynchronously. After release, random bits with no comma pattern → locked stays 0 and dataValid never pulses.
- Lock: random bits, then K28.5 RD− (0011111010), RD+ (1100000101), RD− → locked=1 on the 30th comma bit, RDout=1, no dataValid.
- Ordering: continue with K28.5 RD+, then 0110001011 → dataValid with dataOut=8'h00, no errors, RDout=0. Follow with 1010101010 → dataOut=8'hB5, RDout stays 0.
- Disparity error: at RD−, send 1001110100 → dataOut=8'h00, dispErr=1, codeErr=0, RDout=1.
- Code error / unlock: send four 0000000000 words → codeErr=1 each. locked drops on the 4th. A valid word sent after the 3rd instead resets the count and keeps lock.
- Misaligned comma: while LOCKED, shift the stream by one bit so a comma appears off-boundary → no realignment, errors counted, re-hunt, relock after 3 commas.
